// File: rtl/alu.sv
// Registered 8-bit ALU with a 16-bit result: sixteen commands, one-cycle latency, enable-gated capture.
// Define ALU_DIVIDER_EN to build the DIV command; otherwise DIV returns 0x0000.
module alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic [3:0]  command,
  input  logic        en,
  output logic [15:0] out
);

  typedef enum logic [3:0] {
    CMD_ADD  = 4'd0,
    CMD_INC  = 4'd1,
    CMD_SUB  = 4'd2,
    CMD_DEC  = 4'd3,
    CMD_MUL  = 4'd4,
    CMD_DIV  = 4'd5,
    CMD_SHL  = 4'd6,
    CMD_SHR  = 4'd7,
    CMD_AND  = 4'd8,
    CMD_OR   = 4'd9,
    CMD_INV  = 4'd10,
    CMD_NAND = 4'd11,
    CMD_NOR  = 4'd12,
    CMD_XOR  = 4'd13,
    CMD_XNOR = 4'd14,
    CMD_BUF  = 4'd15
  } cmd_e;

  cmd_e        cmd;
  logic [15:0] a_ext;
  logic [15:0] b_ext;
  logic [15:0] div_res;
  logic [15:0] result;
  logic [15:0] out_d;
  logic [15:0] out_q;

  assign cmd   = cmd_e'(command);
  assign a_ext = {8'h00, a};
  assign b_ext = {8'h00, b};

`ifdef ALU_DIVIDER_EN
  logic [7:0] quot;

  // Divisor is forced nonzero in the b=0 case so the divider never sees x/0.
  assign quot    = a / ((b == 8'd0) ? 8'd1 : b);
  assign div_res = (b == 8'd0) ? 16'hFFFF : {8'h00, quot};
`else
  assign div_res = 16'h0000;
`endif

  always_comb begin
    result = 16'h0000;
    case (cmd)
      CMD_ADD:  result = a_ext + b_ext;
      CMD_INC:  result = a_ext + 16'd1;
      CMD_SUB:  result = a_ext - b_ext;
      CMD_DEC:  result = a_ext - 16'd1;
      CMD_MUL:  result = a_ext * b_ext;
      CMD_DIV:  result = div_res;
      CMD_SHL:  result = {7'b0, a, 1'b0};
      CMD_SHR:  result = {9'b0, a[7:1]};
      CMD_AND:  result = {8'h00, a & b};
      CMD_OR:   result = {8'h00, a | b};
      CMD_INV:  result = {8'h00, ~a};
      CMD_NAND: result = {8'h00, ~(a & b)};
      CMD_NOR:  result = {8'h00, ~(a | b)};
      CMD_XOR:  result = {8'h00, a ^ b};
      CMD_XNOR: result = {8'h00, ~(a ^ b)};
      CMD_BUF:  result = a_ext;
      default:  result = 16'h0000;
    endcase
  end

  always_comb begin
    out_d = out_q;
    if (en) out_d = result;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_q <= 16'h0000;
    else        out_q <= out_d;
  end

  assign out = out_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, reset/enable sequences,
// exhaustive 4-bit operand sweep and random traffic against an arithmetic reference model.
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [3:0]  command;
  logic        en;
  logic [15:0] out;

  int tests_run;
  int tests_failed;

  alu dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .b       (b),
    .command (command),
    .en      (en),
    .out     (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  cmd;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

`ifdef ALU_DIVIDER_EN
  localparam logic [15:0] DIV_10_5 = 16'd2;
  localparam logic [15:0] DIV_7_0  = 16'hFFFF;
`else
  localparam logic [15:0] DIV_10_5 = 16'h0000;
  localparam logic [15:0] DIV_7_0  = 16'h0000;
`endif

  // Reference computed from the operation rules with plain integer arithmetic.
  function automatic logic [15:0] ref_model(input int ai, input int bi, input int ci);
    int r;
    case (ci)
      0:  r = ai + bi;
      1:  r = ai + 1;
      2:  r = ai - bi;
      3:  r = ai - 1;
      4:  r = ai * bi;
`ifdef ALU_DIVIDER_EN
      5:  r = (bi == 0) ? 65535 : ai / bi;
`else
      5:  r = 0;
`endif
      6:  r = ai * 2;
      7:  r = ai / 2;
      8:  r = ai & bi;
      9:  r = ai | bi;
      10: r = 255 - ai;
      11: r = 255 - (ai & bi);
      12: r = 255 - (ai | bi);
      13: r = ai ^ bi;
      14: r = 255 - (ai ^ bi);
      default: r = ai;
    endcase
    return 16'(r);
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, got, exp);
    end
  endtask

  task automatic add_vec(input logic [7:0] va, input logic [7:0] vb, input logic [3:0] vc,
                         input logic [15:0] ve, input string vn);
    vec_t v;
    v.a = va; v.b = vb; v.cmd = vc; v.exp = ve; v.name = vn;
    vecs.push_back(v);
  endtask

  // Drive inputs just after an edge, let the next edge capture, sample 1 time unit later.
  task automatic step(input logic [7:0] va, input logic [7:0] vb, input logic [3:0] vc, input logic ven);
    a = va; b = vb; command = vc; en = ven;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] exp_out;
    tests_run    = 0;
    tests_failed = 0;

    add_vec(8'd10,  8'd5,   4'd2,  16'd5,     "sub_10_5");
    add_vec(8'd10,  8'd5,   4'd4,  16'd50,    "mul_10_5");
    add_vec(8'd10,  8'd5,   4'd5,  DIV_10_5,  "div_10_5");
    add_vec(8'd10,  8'd5,   4'd1,  16'd11,    "inc_10");
    add_vec(8'd10,  8'd5,   4'd3,  16'd9,     "dec_10");
    add_vec(8'd255, 8'd255, 4'd0,  16'd510,   "add_255_255");
    add_vec(8'd255, 8'd255, 4'd4,  16'd65025, "mul_255_255");
    add_vec(8'd0,   8'd0,   4'd3,  16'hFFFF,  "dec_0");
    add_vec(8'd3,   8'd5,   4'd2,  16'hFFFE,  "sub_3_5");
    add_vec(8'hA5,  8'h0F,  4'd6,  16'h014A,  "shl");
    add_vec(8'hA5,  8'h0F,  4'd7,  16'h0052,  "shr");
    add_vec(8'hA5,  8'h0F,  4'd8,  16'h0005,  "and");
    add_vec(8'hA5,  8'h0F,  4'd9,  16'h00AF,  "or");
    add_vec(8'hA5,  8'h0F,  4'd13, 16'h00AA,  "xor");
    add_vec(8'hA5,  8'h0F,  4'd10, 16'h005A,  "inv");
    add_vec(8'hA5,  8'h0F,  4'd11, 16'h00FA,  "nand");
    add_vec(8'hA5,  8'h0F,  4'd12, 16'h0050,  "nor");
    add_vec(8'hA5,  8'h0F,  4'd14, 16'h0055,  "xnor");
    add_vec(8'hA5,  8'h0F,  4'd15, 16'h00A5,  "buf");
    add_vec(8'd7,   8'd0,   4'd5,  DIV_7_0,   "div_by_zero");

    rst_n = 1'b0; en = 1'b0; a = '0; b = '0; command = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_value", out, 16'h0000);
    rst_n = 1'b1;

    // Async reset: load 0x00C8, then pull rst_n low between edges.
    step(8'd100, 8'd100, 4'd0, 1'b1);
    check("pre_reset_load", out, 16'h00C8);
    #2 rst_n = 1'b0;
    #1 check("async_reset_no_clock", out, 16'h0000);
    @(posedge clk); #1;
    check("reset_held", out, 16'h0000);
    rst_n = 1'b1;
    step(8'd10, 8'd10, 4'd0, 1'b1);
    check("first_after_release", out, 16'd20);

    foreach (vecs[i]) begin
      step(vecs[i].a, vecs[i].b, vecs[i].cmd, 1'b1);
      check(vecs[i].name, out, vecs[i].exp);
    end

    // Enable hold.
    step(8'd1, 8'd2, 4'd0, 1'b1);
    check("en_load", out, 16'd3);
    step(8'd9, 8'd9, 4'd4, 1'b0);
    check("en_hold_1", out, 16'd3);
    step(8'd9, 8'd9, 4'd4, 1'b0);
    check("en_hold_2", out, 16'd3);
    step(8'd9, 8'd9, 4'd4, 1'b1);
    check("en_reload", out, 16'd81);

    // Exhaustive small-operand sweep, back-to-back.
    for (int ai = 0; ai < 16; ai++)
      for (int bi = 0; bi < 16; bi++)
        for (int ci = 0; ci < 16; ci++) begin
          step(8'(ai), 8'(bi), 4'(ci), 1'b1);
          check("sweep", out, ref_model(ai, bi, ci));
        end

    // Random traffic with random enable.
    exp_out = out;
    for (int n = 0; n < 500; n++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic [3:0] rc;
      logic       re;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 4'($urandom_range(0, 15));
      re = ($urandom_range(0, 3) != 0);
      if (re) exp_out = ref_model(int'(ra), int'(rb), int'(rc));
      step(ra, rb, rc, re);
      check("random", out, exp_out);
    end

    // Reset during an active operation discards the pending result.
    a = 8'd50; b = 8'd3; command = 4'd4; en = 1'b1;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    check("reset_mid_op", out, 16'h0000);
    rst_n = 1'b1;
    step(8'd50, 8'd3, 4'd4, 1'b1);
    check("after_mid_op_reset", out, 16'd150);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
